uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Byte FIFO and transmit sequencer placed between the UART receive/cipher path and the UART transmitter. It accepts single-cycle byte strobes (receiver data_valid with the cipher output), buffers up to DEPTH bytes, and drains them one at a time into the transmitter using a start/busy handshake. Back-to-back received bytes are therefore not lost while the transmitter is busy, as they would be with direct strobe-to-start forwarding.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 2
WIDTH, 8, data width in bits
BUSY_WAIT, 4, max cycles to wait for tx_busy to rise after tx_start; >= 1

Ports:
clk50  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous reset, active-low
in_valid  input  1  one-cycle strobe: in_data is valid
in_data  input  WIDTH  byte to enqueue
tx_busy  input  1  transmitter busy, from uarttx
tx_start  output  1  one-cycle start pulse to uarttx
tx_data  output  WIDTH  byte to transmit; held stable between starts
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
overflow  output  1  sticky: a byte was dropped
drop_cnt  output  8  dropped-byte counter (see Optional Feature)

Behaviour:
- Reset: sampled on the clk50 edge while reset_n == 0. After reset: tx_start=0, tx_data=0, count=0, empty=1, full=0, overflow=0, drop_cnt=0, pointers=0, FSM=IDLE. A reset mid-transfer discards all stored bytes and any pending start. No tx_start is issued while reset_n is low.
- Write: when in_valid=1 and full=0 (registered value at that edge), store in_data at wr_ptr. Then wr_ptr+1 and count+1. Pointers wrap modulo DEPTH.
- Overflow: when in_valid=1 and full=1, drop the byte and set overflow=1 (sticky until reset). A pop in the same cycle does not rescue the byte, because full is the pre-edge value.
- Pop: occurs on the same edge that drives tx_start high. tx_data <= mem[rd_ptr], then rd_ptr+1 and count-1.
- Simultaneous write and pop: count is unchanged, and both pointers advance.
- FSM, all outputs registered:
  - IDLE: if !empty && !tx_busy, then pop, tx_start<=1, go to ARM with wait counter=0. Otherwise stay.
  - ARM: tx_start<=0. If tx_busy=1, go to DRAIN. Else increment the wait counter. On reaching BUSY_WAIT, go to IDLE; this covers a byte accepted with no visible busy.
  - DRAIN: wait until tx_busy=0, then go to IDLE.
- tx_start is high for exactly one cycle per popped byte. It never asserts twice without a pop in between.
- Latency: in_valid at edge N into an empty FIFO with idle transmitter gives tx_start high in the cycle after edge N+1, with tx_data valid in that same cycle.
- Minimum gap between starts: 1 cycle after tx_busy falls (DRAIN→IDLE→pop).
- tx_busy high while in IDLE, caused by an external transmitter: no pop until it falls.
- Storage: the memory needs no reset. Only pointers, count, flags and outputs are reset.

Optional Feature:
UART_TX_FIFO_DROP_CNT_EN
- Defined: drop_cnt increments by 1 on each dropped byte and saturates at 255. It clears only on reset.
- Undefined: drop_cnt is tied to 0 and no counter logic is built. overflow behaves identically in both cases.

Test Plan:
1. Reset, then in_valid with 0x41, tx_busy held 0 → tx_start single pulse two edges later, tx_data=0x41, count returns to 0, empty=1.
2. Burst 0x10..0x14 on 5 consecutive cycles, model transmitter busy for 20 cycles per byte → tx_data sequence 0x10,0x11,0x12,0x13,0x14. Exactly 5 tx_start pulses, none while busy=1, overflow=0.
3. tx_busy forced 1, write 17 bytes with DEPTH=16 → full=1 after the 16th, 17th dropped, overflow=1. drop_cnt=1 with macro, 0 without. Release busy → 16 bytes out in order.
4. Write at full in the same cycle as a pop → byte dropped, count=15 after the edge.
5. Transmitter that never raises busy → ARM times out after BUSY_WAIT=4 cycles and the next byte starts. No deadlock, and all bytes are emitted.
6. Assert reset_n=0 during DRAIN with 5 bytes queued → next edge count=0, tx_start=0, overflow=0. No further starts after release until new writes arrive.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// Byte FIFO and transmit sequencer that sits between the UART receive/cipher
// path and the UART transmitter. It enqueues single-cycle byte strobes, holds
// up to DEPTH bytes, and hands them to the transmitter one at a time using a
// start/busy handshake. Bytes that arrive while the transmitter is busy are
// therefore kept instead of being lost.
//
// Optional build macro: UART_TX_FIFO_DROP_CNT_EN
//   defined   -> drop_cnt counts dropped bytes and saturates at 255
//   undefined -> drop_cnt is tied to zero and no counter logic is built
//
// Ports:
//   clk50     in   system clock; all logic runs on the rising edge
//   reset_n   in   synchronous reset, active-low
//   in_valid  in   one-cycle strobe qualifying in_data
//   in_data   in   byte to enqueue
//   tx_busy   in   transmitter busy flag
//   tx_start  out  one-cycle start pulse, one per popped byte
//   tx_data   out  byte to transmit, held stable between starts
//   count     out  current occupancy, 0..DEPTH
//   empty     out  occupancy is zero
//   full      out  occupancy is DEPTH
//   overflow  out  sticky flag: at least one byte was dropped
//   drop_cnt  out  number of dropped bytes (optional feature)
module uart_tx_fifo #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int BUSY_WAIT = 4
) (
  input  logic                   clk50,
  input  logic                   reset_n,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [WIDTH-1:0]       tx_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    DRAIN
  } state_t;

  state_t         r_state;
  state_t         w_stateNext;
  logic [CW-1:0]  r_waitCnt;
  logic [CW-1:0]  w_waitCntNext;
  logic [AW-1:0]  r_wrPtr;
  logic [AW-1:0]  r_rdPtr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic           w_wr;
  logic           w_pop;

  // Flags decode the registered occupancy, so a write is judged against the
  // pre-edge full value and a same-cycle pop cannot rescue it.
  assign empty = (count == '0);
  assign full  = (count == (AW + 1)'(DEPTH));
  assign w_wr  = in_valid && !full;

  // Sequencer next-state logic. A pop only happens from IDLE, so tx_start can
  // never fire twice for the same byte. ARM gives the transmitter BUSY_WAIT
  // cycles to show busy; a transmitter that never raises busy still drains.
  always_comb begin
    w_stateNext   = r_state;
    w_waitCntNext = r_waitCnt;
    w_pop         = 1'b0;
    case (r_state)
      IDLE: begin
        if (!empty && !tx_busy) begin
          w_pop         = 1'b1;
          w_stateNext   = ARM;
          w_waitCntNext = '0;
        end
      end
      ARM: begin
        if (tx_busy) begin
          w_stateNext = DRAIN;
        end else if (r_waitCnt == CW'(BUSY_WAIT - 1)) begin
          w_stateNext = IDLE;
        end else begin
          w_waitCntNext = r_waitCnt + 1'b1;
        end
      end
      DRAIN: begin
        if (!tx_busy) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Storage array; left unreset because pointers and count define validity.
  always_ff @(posedge clk50) begin
    if (w_wr) begin
      r_mem[r_wrPtr] <= in_data;
    end
  end

  // Control registers, pointers, occupancy and registered outputs.
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_waitCnt <= '0;
      r_wrPtr   <= '0;
      r_rdPtr   <= '0;
      count     <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      overflow  <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_waitCnt <= w_waitCntNext;
      tx_start  <= w_pop;
      if (w_wr) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        tx_data <= r_mem[r_rdPtr];
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_wr && !w_pop) begin
        count <= count + 1'b1;
      end else if (!w_wr && w_pop) begin
        count <= count - 1'b1;
      end
      if (in_valid && full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_DROP_CNT_EN
  // Saturating drop counter; it only ever clears on reset.
  always_ff @(posedge clk50) begin
    if (!reset_n) begin
      drop_cnt <= 8'd0;
    end else if (in_valid && full && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo
// Directed and randomized bench for uart_tx_fifo. A queue-based reference
// model tracks the bytes held in the FIFO, the sticky overflow flag and the
// drop count, while a small transmitter model answers tx_start with busy.
module tb_uart_tx_fifo;

  localparam int DEPTH     = 16;
  localparam int WIDTH     = 8;
  localparam int BUSY_WAIT = 4;

  logic             clk50;
  logic             reset_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             tx_busy;
  logic             tx_start;
  logic [WIDTH-1:0] tx_data;
  logic [$clog2(DEPTH):0] count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic [7:0]       drop_cnt;

  uart_tx_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(WIDTH),
    .BUSY_WAIT(BUSY_WAIT)
  ) dut (
    .clk50(clk50),
    .reset_n(reset_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .tx_busy(tx_busy),
    .tx_start(tx_start),
    .tx_data(tx_data),
    .count(count),
    .empty(empty),
    .full(full),
    .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  // Free-running 50 MHz clock.
  initial clk50 = 1'b0;
  always #10 clk50 = ~clk50;

  int               assertCount = 0;
  int               failCount   = 0;
  int               cycle       = 0;
  int               startCount  = 0;
  int               startCycles [$];
  logic [WIDTH-1:0] modelQ [$];
  logic [WIDTH-1:0] modelTxData = '0;
  logic             modelOvf    = 1'b0;
  int               modelDrops  = 0;
  int               busyMode    = 0;
  int               busyLen     = 20;
  int               busyLeft    = 0;
  bit               busyRand    = 1'b0;

  // Single comparison point: every check is one immediate assertion.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the reference model after an edge.
  task automatic checkOutput();
    int expDrop;
`ifdef UART_TX_FIFO_DROP_CNT_EN
    expDrop = modelDrops;
`else
    expDrop = 0;
`endif
    checkVal("count", 32'(count), 32'(modelQ.size()));
    checkVal("empty", 32'(empty), 32'(modelQ.size() == 0));
    checkVal("full", 32'(full), 32'(modelQ.size() == DEPTH));
    checkVal("overflow", 32'(overflow), 32'(modelOvf));
    checkVal("drop_cnt", 32'(drop_cnt), 32'(expDrop));
    checkVal("tx_data", 32'(tx_data), 32'(modelTxData));
  endtask

  // Drive one cycle of input, advance the model across the edge, check the
  // DUT, then let the transmitter model react to what it just saw.
  task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] data);
    bit preFull;
    bit preBusy;
    bit preReset;
    in_valid = valid;
    in_data  = data;
    preFull  = (modelQ.size() == DEPTH);
    preBusy  = tx_busy;
    preReset = reset_n;
    @(posedge clk50);
    #1;
    cycle++;
    if (!preReset) begin
      modelQ.delete();
      modelOvf    = 1'b0;
      modelDrops  = 0;
      modelTxData = '0;
      checkVal("startInReset", 32'(tx_start), 32'd0);
    end else begin
      if (tx_start === 1'b1) begin
        startCount++;
        startCycles.push_back(cycle);
        checkVal("startWhileBusy", 32'(preBusy), 32'd0);
        checkVal("startWithData", 32'(modelQ.size() != 0), 32'd1);
        if (modelQ.size() != 0) modelTxData = modelQ.pop_front();
      end
      if (valid) begin
        if (!preFull) begin
          modelQ.push_back(data);
        end else begin
          modelOvf = 1'b1;
          if (modelDrops < 255) modelDrops++;
        end
      end
    end
    checkOutput();
    case (busyMode)
      0: tx_busy = 1'b0;
      1: begin
        if (tx_start === 1'b1) begin
          tx_busy  = 1'b1;
          busyLeft = busyRand ? int'($urandom_range(1, 8)) : busyLen;
        end else if (busyLeft > 0) begin
          busyLeft--;
          if (busyLeft == 0) tx_busy = 1'b0;
        end
      end
      default: tx_busy = 1'b1;
    endcase
    in_valid = 1'b0;
  endtask

  task automatic setBusyMode(input int mode, input int len);
    busyMode = mode;
    busyLen  = len;
    busyLeft = 0;
    tx_busy  = (mode == 2);
  endtask

  // Run idle cycles until the model is empty and the transmitter is quiet,
  // then a few more so the sequencer is back in its waiting state.
  task automatic drainAll(input int budget);
    int n;
    n = 0;
    while ((modelQ.size() != 0 || tx_busy) && n < budget) begin
      applyStimulus(1'b0, '0);
      n++;
    end
    checkVal("drainTimeout", 32'(modelQ.size()), 32'd0);
    repeat (BUSY_WAIT + 3) applyStimulus(1'b0, '0);
  endtask

  initial begin
    int startsBefore;
    int gap;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    tx_busy  = 1'b0;

    // Reset state.
    $display("[TB] reset");
    applyStimulus(1'b0, '0);
    applyStimulus(1'b0, '0);
    checkVal("resetStart", 32'(tx_start), 32'd0);
    checkVal("resetEmpty", 32'(empty), 32'd1);
    reset_n = 1'b1;
    applyStimulus(1'b0, '0);

    // Single byte with idle transmitter: start two edges after the write.
    $display("[TB] single byte latency");
    setBusyMode(0, 0);
    applyStimulus(1'b1, 8'h41);
    checkVal("t1StartEarly", 32'(tx_start), 32'd0);
    applyStimulus(1'b0, '0);
    checkVal("t1Start", 32'(tx_start), 32'd1);
    checkVal("t1Data", 32'(tx_data), 32'h41);
    checkVal("t1Count", 32'(count), 32'd0);
    checkVal("t1Empty", 32'(empty), 32'd1);
    applyStimulus(1'b0, '0);
    checkVal("t1Pulse", 32'(tx_start), 32'd0);
    drainAll(100);

    // Five-byte burst against a transmitter busy for 20 cycles per byte.
    $display("[TB] burst with busy transmitter");
    setBusyMode(1, 20);
    startsBefore = startCount;
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h10 + i));
    drainAll(1000);
    checkVal("t2Starts", 32'(startCount - startsBefore), 32'd5);
    checkVal("t2Ovf", 32'(overflow), 32'd0);

    // Fill while busy, overflow by one, then drop a write on the pop edge.
    $display("[TB] fill and overflow");
    setBusyMode(2, 0);
    applyStimulus(1'b0, '0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 8'($urandom));
    checkVal("t3Full", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'($urandom));
    checkVal("t3Ovf", 32'(overflow), 32'd1);
    checkVal("t3Count", 32'(count), 32'(DEPTH));
    setBusyMode(1, 3);
    applyStimulus(1'b1, 8'hEE);
    checkVal("t4Start", 32'(tx_start), 32'd1);
    checkVal("t4Count", 32'(count), 32'(DEPTH - 1));
    drainAll(2000);

    // Transmitter that never shows busy: each byte follows an ARM timeout.
    $display("[TB] busy timeout");
    setBusyMode(0, 0);
    startCycles.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'($urandom));
    drainAll(200);
    checkVal("t5Starts", 32'(startCycles.size()), 32'd4);
    for (int i = 1; i < startCycles.size(); i++) begin
      gap = startCycles[i] - startCycles[i-1];
      checkVal("t5Gap", 32'(gap), 32'(BUSY_WAIT + 1));
    end

    // Random traffic against a transmitter with random busy lengths.
    $display("[TB] random traffic");
    setBusyMode(1, 0);
    busyRand = 1'b1;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom_range(0, 2) == 0), 8'($urandom));
    end
    drainAll(5000);
    busyRand = 1'b0;

    // Reset while draining with bytes still queued.
    $display("[TB] reset mid-transfer");
    setBusyMode(1, 20);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 8'($urandom));
    checkVal("t6Queued", 32'(count), 32'd5);
    reset_n = 1'b0;
    applyStimulus(1'b0, '0);
    checkVal("t6Count", 32'(count), 32'd0);
    checkVal("t6Start", 32'(tx_start), 32'd0);
    checkVal("t6Ovf", 32'(overflow), 32'd0);
    reset_n = 1'b1;
    setBusyMode(0, 0);
    startsBefore = startCount;
    repeat (10) applyStimulus(1'b0, '0);
    checkVal("t6NoStart", 32'(startCount - startsBefore), 32'd0);
    applyStimulus(1'b1, 8'h5A);
    applyStimulus(1'b0, '0);
    checkVal("t6Restart", 32'(tx_start), 32'd1);
    checkVal("t6Data", 32'(tx_data), 32'h5A);
    drainAll(100);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
